// File: rtl/qspi_flash_pkg.sv
// Shared states and protocol constants for the QSPI Quad I/O Fast Read controller.
package qspi_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    MODE,
    DUMMY,
    DATA
  } qspi_state_e;

  localparam logic [7:0] CMD_QUAD_READ = 8'hEB;
  localparam logic [7:0] MODE_CONT     = 8'hA0;
  localparam logic [7:0] MODE_NONE     = 8'hFF;
  localparam int         DUMMY_CYCLES  = 4;
  localparam int         ADDR_NIBBLES  = 6;
  localparam int         CMD_BITS      = 8;
  localparam int         MODE_NIBBLES  = 2;

endpackage

// File: rtl/qspi_nibble_shifter.sv
// SPI bit-period engine: phase toggle, per-segment period down-counter,
// registered output shifter (1-bit or 4-bit) and input nibble shift register.
module qspi_nibble_shifter
  import qspi_flash_pkg::*;
#(
  parameter int RX_BITS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               ld,
  input  logic               ld_lead,
  input  logic               ld_quad,
  input  logic [2:0]         ld_cnt,
  input  logic [23:0]        ld_val,
  input  logic               hold,
  input  logic [3:0]         spi_data_in,
  output logic               spi_clk_out,
  output logic [3:0]         spi_data_out,
  output logic               seg_end,
  output logic [RX_BITS-1:0] rx_word
);

  logic               clk_q, clk_d;
  logic               lead_q, lead_d;
  logic               quad_q, quad_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [23:0]        tx_q, tx_d;
  logic [3:0]         dout_q, dout_d;
  logic [RX_BITS-1:0] rx_q, rx_d;

  assign spi_clk_out  = clk_q;
  assign spi_data_out = dout_q;
  assign seg_end      = clk_q && (cnt_q == 3'd0);
  assign rx_word      = {rx_q[RX_BITS-5:0], spi_data_in};

  always_comb begin
    clk_d  = clk_q;
    lead_d = lead_q;
    quad_d = quad_q;
    cnt_d  = cnt_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    if (clr) begin
      clk_d  = 1'b0;
      lead_d = 1'b0;
      quad_d = 1'b0;
      cnt_d  = '0;
      tx_d   = '0;
    end else begin
      if (clk_q) begin
        // Edge ending phase B: capture the nibble and move to the next period.
        clk_d = 1'b0;
        rx_d  = rx_word;
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
          tx_d  = quad_q ? {tx_q[19:0], 4'h0} : {tx_q[22:0], 1'b0};
        end
      end else if (lead_q) begin
        lead_d = 1'b0;
      end else if (!hold) begin
        clk_d = 1'b1;
      end
      if (ld) begin
        clk_d  = 1'b0;
        lead_d = ld_lead;
        quad_d = ld_quad;
        cnt_d  = ld_cnt;
        tx_d   = ld_val;
      end
    end
    dout_d = quad_d ? tx_d[23:20] : {3'b000, tx_d[23]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_q  <= 1'b0;
      lead_q <= 1'b0;
      quad_q <= 1'b0;
      cnt_q  <= '0;
      tx_q   <= '0;
      dout_q <= '0;
      rx_q   <= '0;
    end else begin
      clk_q  <= clk_d;
      lead_q <= lead_d;
      quad_q <= quad_d;
      cnt_q  <= cnt_d;
      tx_q   <= tx_d;
      dout_q <= dout_d;
      rx_q   <= rx_d;
    end
  end

endmodule

// File: rtl/qspi_flash_ctrl.sv
// Read-only QSPI NOR controller (Quad I/O Fast Read 0xEB, streaming words).
// QSPI_CONT_READ_EN enables continuous-read mode (mode byte 0xA0, CMD skipped after the first read).
//   state | meaning
//   IDLE  | deselected, waiting for start_read
//   CMD   | 0xEB on IO0, 8 periods
//   ADDR  | 24-bit address, 6 quad periods
//   MODE  | mode byte, 2 quad periods
//   DUMMY | 4 periods, bus released
//   DATA  | 2*DATA_WIDTH_BYTES nibbles per word, repeating
module qspi_flash_ctrl
  import qspi_flash_pkg::*;
#(
  parameter int DATA_WIDTH_BYTES = 4,
  parameter int ADDR_BITS        = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    spi_data_in,
  output logic [3:0]                    spi_data_out,
  output logic [3:0]                    spi_data_oe,
  output logic                          spi_select,
  output logic                          spi_clk_out,
  input  logic [ADDR_BITS-1:0]          addr_in,
  input  logic                          start_read,
  input  logic                          stall_read,
  input  logic                          stop_read,
  output logic [8*DATA_WIDTH_BYTES-1:0] data_out,
  output logic                          data_ready,
  output logic                          busy
);

  localparam int         WB       = 8 * DATA_WIDTH_BYTES;
  localparam logic [2:0] CMD_CNT  = 3'(CMD_BITS - 1);
  localparam logic [2:0] ADDR_CNT = 3'(ADDR_NIBBLES - 1);
  localparam logic [2:0] MODE_CNT = 3'(MODE_NIBBLES - 1);
  localparam logic [2:0] DUM_CNT  = 3'(DUMMY_CYCLES - 1);
  localparam logic [2:0] DATA_CNT = 3'(2 * DATA_WIDTH_BYTES - 1);

  qspi_state_e   state_q, state_d;
  logic [23:0]   addr_q, addr_d, addr24;
  logic [WB-1:0] data_out_q, data_out_d, word_swapped, rx_word;
  logic          data_ready_q, data_ready_d;
  logic          select_q, select_d;
  logic [3:0]    oe_q, oe_d;
  logic          clr, ld, ld_lead, ld_quad, hold, seg_end;
  logic [2:0]    ld_cnt;
  logic [23:0]   ld_val;
  logic          cont_q;

`ifdef QSPI_CONT_READ_EN
  localparam logic [7:0] MODE_BYTE = MODE_CONT;
  logic cont_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cont_q <= 1'b0;
    else     cont_q <= cont_d;
  end
`else
  localparam logic [7:0] MODE_BYTE = MODE_NONE;
  assign cont_q = 1'b0;
`endif

  assign addr24       = 24'(addr_in);
  assign hold         = data_ready_q && stall_read;
  assign data_out     = data_out_q;
  assign data_ready   = data_ready_q;
  assign spi_select   = select_q;
  assign spi_data_oe  = oe_q;
  assign busy         = ~select_q;

  // Bytes arrive first-byte-first in rx_word; the first byte belongs in the low lane.
  always_comb begin
    word_swapped = '0;
    for (int k = 0; k < DATA_WIDTH_BYTES; k++) begin
      word_swapped[8*k +: 8] = rx_word[8*(DATA_WIDTH_BYTES-1-k) +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_out_d   = data_out_q;
    data_ready_d = data_ready_q && stall_read;
    clr          = 1'b0;
    ld           = 1'b0;
    ld_lead      = 1'b0;
    ld_quad      = 1'b0;
    ld_cnt       = '0;
    ld_val       = '0;
`ifdef QSPI_CONT_READ_EN
    cont_d       = cont_q;
`endif
    if (state_q == IDLE) begin
      clr          = 1'b1;
      data_ready_d = 1'b0;
      if (start_read && !stop_read) begin
        clr     = 1'b0;
        ld      = 1'b1;
        ld_lead = 1'b1;
        addr_d  = addr24;
        if (cont_q) begin
          state_d = ADDR;
          ld_quad = 1'b1;
          ld_cnt  = ADDR_CNT;
          ld_val  = addr24;
        end else begin
          state_d = CMD;
          ld_cnt  = CMD_CNT;
          ld_val  = {CMD_QUAD_READ, 16'h0000};
        end
      end
    end else if (stop_read) begin
      state_d      = IDLE;
      clr          = 1'b1;
      data_ready_d = 1'b0;
    end else if (seg_end) begin
      ld = 1'b1;
      case (state_q)
        CMD: begin
          state_d = ADDR;
          ld_quad = 1'b1;
          ld_cnt  = ADDR_CNT;
          ld_val  = addr_q;
        end
        ADDR: begin
          state_d = MODE;
          ld_quad = 1'b1;
          ld_cnt  = MODE_CNT;
          ld_val  = {MODE_BYTE, 16'h0000};
        end
        MODE: begin
          state_d = DUMMY;
          ld_cnt  = DUM_CNT;
`ifdef QSPI_CONT_READ_EN
          cont_d  = 1'b1;
`endif
        end
        DUMMY, DATA: begin
          state_d = DATA;
          ld_cnt  = DATA_CNT;
          if (state_q == DATA) begin
            data_out_d   = word_swapped;
            data_ready_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          ld      = 1'b0;
          clr     = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    select_d = (state_d == IDLE);
    case (state_d)
      CMD:        oe_d = 4'b0001;
      ADDR, MODE: oe_d = 4'b1111;
      default:    oe_d = 4'b0000;
    endcase
  end

  qspi_nibble_shifter #(.RX_BITS(WB)) u_shifter (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .ld           (ld),
    .ld_lead      (ld_lead),
    .ld_quad      (ld_quad),
    .ld_cnt       (ld_cnt),
    .ld_val       (ld_val),
    .hold         (hold),
    .spi_data_in  (spi_data_in),
    .spi_clk_out  (spi_clk_out),
    .spi_data_out (spi_data_out),
    .seg_end      (seg_end),
    .rx_word      (rx_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_out_q   <= '0;
      data_ready_q <= 1'b0;
      select_q     <= 1'b1;
      oe_q         <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_out_q   <= data_out_d;
      data_ready_q <= data_ready_d;
      select_q     <= select_d;
      oe_q         <= oe_d;
    end
  end

endmodule

// File: tb/tb_qspi_flash_ctrl.sv
// Directed bench for qspi_flash_ctrl with a small behavioural QSPI flash model.
module tb_qspi_flash_ctrl;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   spi_data_in = 4'h0;
  logic [3:0]   spi_data_out;
  logic [3:0]   spi_data_oe;
  logic         spi_select;
  logic         spi_clk_out;
  logic [23:0]  addr_in = 24'h0;
  logic         start_read = 1'b0;
  logic         stall_read = 1'b0;
  logic         stop_read = 1'b0;
  logic [15:0]  data_out;
  logic         data_ready;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit cont_active = 1'b0;

  int         pcnt = 0;
  logic [3:0] rec_oe [0:63];
  logic [3:0] rec_do [0:63];
  logic [7:0] model_bytes [0:7] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

  always #5 clk = ~clk;

  qspi_flash_ctrl #(.DATA_WIDTH_BYTES(W), .ADDR_BITS(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_data_in  (spi_data_in),
    .spi_data_out (spi_data_out),
    .spi_data_oe  (spi_data_oe),
    .spi_select   (spi_select),
    .spi_clk_out  (spi_clk_out),
    .addr_in      (addr_in),
    .start_read   (start_read),
    .stall_read   (stall_read),
    .stop_read    (stop_read),
    .data_out     (data_out),
    .data_ready   (data_ready),
    .busy         (busy)
  );

  // Flash model: records each period's pins at SCK rise, presents read data for DATA periods.
  always @(posedge spi_clk_out or posedge spi_select) begin
    int j;
    if (spi_select) begin
      pcnt = 0;
      spi_data_in = 4'h0;
    end else begin
      if (pcnt < 64) begin
        rec_oe[pcnt] = spi_data_oe;
        rec_do[pcnt] = spi_data_out;
      end
      j = pcnt - (cont_active ? 12 : 20);
      if (j >= 0 && j < 16) spi_data_in = j[0] ? model_bytes[j>>1][3:0] : model_bytes[j>>1][7:4];
      else spi_data_in = 4'h0;
      pcnt++;
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (spi_select !== 1'b1) begin n_bad++; $display("FAIL reset_select: got %b want 1", spi_select); end
    n_cmp++; if (spi_clk_out !== 1'b0) begin n_bad++; $display("FAIL reset_sck: got %b want 0", spi_clk_out); end
    n_cmp++; if (spi_data_oe !== 4'h0) begin n_bad++; $display("FAIL reset_oe: got %h want 0", spi_data_oe); end
    n_cmp++; if (spi_data_out !== 4'h0) begin n_bad++; $display("FAIL reset_dout: got %h want 0", spi_data_out); end
    n_cmp++; if (data_out !== 16'h0) begin n_bad++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    n_cmp++; if (data_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", data_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (spi_select !== 1'b1) begin n_bad++; $display("FAIL idle_select: got %b want 1", spi_select); end
  endtask

  task automatic test_read;
    int n;
    int bad;
    logic [7:0]  b;
    logic [23:0] a;
    logic [7:0]  exp_mode;
`ifdef QSPI_CONT_READ_EN
    exp_mode = 8'hA0;
`else
    exp_mode = 8'hFF;
`endif
    @(negedge clk); addr_in = 24'h123456; start_read = 1'b1;
    @(negedge clk); start_read = 1'b0;
    n_cmp++; if (busy !== 1'b1 || spi_select !== 1'b0) begin n_bad++; $display("FAIL start_select: got busy=%b sel=%b want 1/0", busy, spi_select); end
    n = 0;
    while (data_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_cmp++; if (n != 49) begin n_bad++; $display("FAIL first_latency: got %0d want 49", n); end
    n_cmp++; if (data_out !== 16'h1234) begin n_bad++; $display("FAIL word0: got %h want 1234", data_out); end
    b = 8'h0; bad = 0;
    for (int i = 0; i < 8; i++) begin
      b = {b[6:0], rec_do[i][0]};
      if (rec_oe[i] !== 4'b0001 || rec_do[i][3:1] !== 3'b000) bad++;
    end
    n_cmp++; if (b !== 8'hEB) begin n_bad++; $display("FAIL cmd_byte: got %h want eb", b); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL cmd_oe: got %0d bad periods want 0", bad); end
    a = 24'h0; bad = 0;
    for (int i = 8; i < 14; i++) begin
      a = {a[19:0], rec_do[i]};
      if (rec_oe[i] !== 4'hF) bad++;
    end
    n_cmp++; if (a !== 24'h123456) begin n_bad++; $display("FAIL addr_nibbles: got %h want 123456", a); end
    b = {rec_do[14], rec_do[15]};
    if (rec_oe[14] !== 4'hF || rec_oe[15] !== 4'hF) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL addr_mode_oe: got %0d bad periods want 0", bad); end
    n_cmp++; if (b !== exp_mode) begin n_bad++; $display("FAIL mode_byte: got %h want %h", b, exp_mode); end
    bad = 0;
    for (int i = 16; i < 24; i++) if (rec_oe[i] !== 4'h0) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL dummy_data_oe: got %0d driven periods want 0", bad); end
    @(negedge clk); n = 1;
    n_cmp++; if (data_ready !== 1'b0) begin n_bad++; $display("FAIL ready_pulse: got %b want 0", data_ready); end
    while (data_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_cmp++; if (n != 8) begin n_bad++; $display("FAIL word_spacing: got %0d want 8", n); end
    n_cmp++; if (data_out !== 16'h5678) begin n_bad++; $display("FAIL word1: got %h want 5678", data_out); end
    stop_read = 1'b1;
    @(negedge clk); stop_read = 1'b0;
    n_cmp++; if (spi_select !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b0) begin n_bad++; $display("FAIL read_stop: got sel=%b busy=%b rdy=%b want 1/0/0", spi_select, busy, data_ready); end
`ifdef QSPI_CONT_READ_EN
    cont_active = 1'b1;
`endif
  endtask

`ifdef QSPI_CONT_READ_EN
  task automatic test_cont_read;
    int n;
    logic [23:0] a;
    logic [7:0]  b;
    @(negedge clk); addr_in = 24'h0ABCDE; start_read = 1'b1;
    @(negedge clk); start_read = 1'b0;
    n = 0;
    while (data_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_cmp++; if (n != 33) begin n_bad++; $display("FAIL cont_latency: got %0d want 33", n); end
    a = {rec_do[0], rec_do[1], rec_do[2], rec_do[3], rec_do[4], rec_do[5]};
    n_cmp++; if (a !== 24'h0ABCDE || rec_oe[0] !== 4'hF) begin n_bad++; $display("FAIL cont_addr: got %h oe=%h want 0abcde oe=f", a, rec_oe[0]); end
    b = {rec_do[6], rec_do[7]};
    n_cmp++; if (b !== 8'hA0) begin n_bad++; $display("FAIL cont_mode: got %h want a0", b); end
    n_cmp++; if (data_out !== 16'h1234) begin n_bad++; $display("FAIL cont_word0: got %h want 1234", data_out); end
    stop_read = 1'b1;
    @(negedge clk); stop_read = 1'b0;
  endtask
`endif

  task automatic test_stall;
    int n;
    int bad;
    int exp_p;
    exp_p = (cont_active ? 12 : 20) + 4;
    @(negedge clk); addr_in = 24'h000100; start_read = 1'b1; stall_read = 1'b1;
    @(negedge clk); start_read = 1'b0;
    n = 0;
    while (data_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_cmp++; if (data_out !== 16'h1234) begin n_bad++; $display("FAIL stall_word0: got %h want 1234 (waited %0d)", data_out, n); end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (data_ready !== 1'b1 || spi_clk_out !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
    n_cmp++; if (pcnt != exp_p) begin n_bad++; $display("FAIL stall_no_sck: got %0d periods want %0d", pcnt, exp_p); end
    stall_read = 1'b0;
    @(negedge clk);
    n_cmp++; if (data_ready !== 1'b0) begin n_bad++; $display("FAIL stall_release: got %b want 0", data_ready); end
    n = 0;
    while (data_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_cmp++; if (n >= 40) begin n_bad++; $display("FAIL stall_resume_timeout: got %0d cycles want <40", n); end
    n_cmp++; if (data_out !== 16'h5678) begin n_bad++; $display("FAIL stall_word1: got %h want 5678", data_out); end
    stop_read = 1'b1;
    @(negedge clk); stop_read = 1'b0;
  endtask

  task automatic test_stop_addr;
    int bad;
    @(negedge clk); addr_in = 24'h654321; start_read = 1'b1;
    @(negedge clk); start_read = 1'b0;
    repeat (cont_active ? 6 : 20) @(negedge clk);
    n_cmp++; if (spi_data_oe !== 4'hF) begin n_bad++; $display("FAIL stop_pre_oe: got %h want f", spi_data_oe); end
    stop_read = 1'b1;
    @(negedge clk); stop_read = 1'b0;
    n_cmp++; if (spi_select !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL stop_addr_sel: got sel=%b busy=%b want 1/0", spi_select, busy); end
    n_cmp++; if (spi_clk_out !== 1'b0 || spi_data_oe !== 4'h0) begin n_bad++; $display("FAIL stop_addr_pins: got sck=%b oe=%h want 0/0", spi_clk_out, spi_data_oe); end
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (data_ready !== 1'b0 || spi_select !== 1'b1) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL stop_addr_quiet: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_stop_start;
    int bad;
    @(negedge clk); addr_in = 24'h000010; start_read = 1'b1;
    @(negedge clk); start_read = 1'b0;
    repeat (30) @(negedge clk);
    stop_read = 1'b1; start_read = 1'b1;
    @(negedge clk); stop_read = 1'b0; start_read = 1'b0;
    n_cmp++; if (spi_select !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b0) begin n_bad++; $display("FAIL stop_start: got sel=%b busy=%b rdy=%b want 1/0/0", spi_select, busy, data_ready); end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (spi_select !== 1'b1) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL stop_start_idle: got %0d selected cycles want 0", bad); end
  endtask

  task automatic test_reset_mid;
    int n;
    logic [7:0] b;
    @(negedge clk); addr_in = 24'h000200; start_read = 1'b1;
    @(negedge clk); start_read = 1'b0;
    n = 0;
    while (data_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (spi_select !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_sel: got sel=%b busy=%b want 1/0", spi_select, busy); end
    n_cmp++; if (data_ready !== 1'b0 || spi_clk_out !== 1'b0) begin n_bad++; $display("FAIL rst_mid_pins: got rdy=%b sck=%b want 0/0", data_ready, spi_clk_out); end
    @(negedge clk); rst = 1'b0; cont_active = 1'b0;
    @(negedge clk); addr_in = 24'h000000; start_read = 1'b1;
    @(negedge clk); start_read = 1'b0;
    n = 0;
    while (data_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_cmp++; if (n != 49) begin n_bad++; $display("FAIL rst_restart_latency: got %0d want 49", n); end
    b = 8'h0;
    for (int i = 0; i < 8; i++) b = {b[6:0], rec_do[i][0]};
    n_cmp++; if (b !== 8'hEB) begin n_bad++; $display("FAIL rst_restart_cmd: got %h want eb", b); end
    stop_read = 1'b1;
    @(negedge clk); stop_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
`ifdef QSPI_CONT_READ_EN
    test_cont_read();
`endif
    test_stall();
    test_stop_addr();
    test_stop_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
